// File: rtl/stopwatch_pkg.sv
// Shared types, digit limits and BCD helper for the stopwatch core.
package stopwatch_pkg;

    // Operating modes of the stopwatch controller.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    // Highest legal value of a units digit and of a tens digit.
    localparam logic [3:0] DIGIT_MAX_ONES = 4'd9;
    localparam logic [3:0] DIGIT_MAX_TENS = 4'd5;

    // One BCD digit step: returns {carry, next_digit}.
    // A digit at or above its limit rolls to 0 with carry, so an illegal
    // value can never persist past one advance.
    function automatic logic [4:0] bcd_step(input logic [3:0] digit,
                                            input logic [3:0] limit);
        logic [4:0] result;
        if (digit >= limit) begin
            result = {1'b1, 4'd0};
        end else begin
            result = {1'b0, digit + 4'd1};
        end
        return result;
    endfunction

endpackage

// File: rtl/stopwatch_core_sync_edge.sv
// Synchronizer chain followed by a registered rising-edge detector.
// Produces a one-cycle pulse SYNC_STAGES+1 cycles after the input is first
// sampled high; a held level yields only one pulse.
module sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_pulse
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   r_pulse;

    // Shift the input through the synchronizer and detect a low-to-high step.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync  <= {SYNC_STAGES{1'b0}};
            r_prev  <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], i_d};
            r_prev  <= r_sync[SYNC_STAGES-1];
            r_pulse <= r_sync[SYNC_STAGES-1] & ~r_prev;
        end
    end

    assign o_pulse = r_pulse;

endmodule

// File: rtl/stopwatch_core.sv
// MM:SS stopwatch: synchronized start/clear buttons, tick prescaler,
// IDLE/RUN/PAUSE control and a four-digit BCD time counter with wrap pulse.
module stopwatch_core
    import stopwatch_pkg::*;
#(
    parameter int TICKS_PER_SEC = 1000,
    parameter int SYNC_STAGES   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_in,
    input  logic       btn_start,
    input  logic       btn_clear,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [3:0] min_tens,
    output logic       running,
    output logic       wrap
);

    localparam int PRE_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICKS_PER_SEC - 1);

    logic             w_tick_p;
    logic             w_start_p;
    logic             w_clear_p;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [PRE_W-1:0] r_pre;
    logic [PRE_W-1:0] w_pre_nxt;
    logic [3:0]       r_sec_ones;
    logic [3:0]       r_sec_tens;
    logic [3:0]       r_min_ones;
    logic [3:0]       r_min_tens;
    logic [3:0]       w_sec_ones_nxt;
    logic [3:0]       w_sec_tens_nxt;
    logic [3:0]       w_min_ones_nxt;
    logic [3:0]       w_min_tens_nxt;
    logic             r_running;
    logic             r_wrap;
    logic             w_wrap_nxt;

    logic             w_count;
    logic             w_adv;
    logic [4:0]       w_so_step;
    logic [4:0]       w_st_step;
    logic [4:0]       w_mo_step;
    logic [4:0]       w_mt_step;

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_tick (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_d     (tick_in),
        .o_pulse (w_tick_p)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_start (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_d     (btn_start),
        .o_pulse (w_start_p)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clear (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_d     (btn_clear),
        .o_pulse (w_clear_p)
    );

    // Next-state decode: clear beats start when stopped, start beats clear when running.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_start_p && !w_clear_p) begin
                    w_state_nxt = RUN;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            RUN: begin
                if (w_start_p) begin
                    w_state_nxt = PAUSE;
                end else begin
                    w_state_nxt = RUN;
                end
            end
            PAUSE: begin
                if (w_clear_p) begin
                    w_state_nxt = IDLE;
                end else if (w_start_p) begin
                    w_state_nxt = RUN;
                end else begin
                    w_state_nxt = PAUSE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Prescaler and BCD carry chain; a tick seen in RUN counts even if start leaves RUN.
    always_comb begin
        w_count        = (r_state == RUN) && w_tick_p;
        w_adv          = w_count && (r_pre == PRE_MAX);
        w_so_step      = bcd_step(r_sec_ones, DIGIT_MAX_ONES);
        w_st_step      = bcd_step(r_sec_tens, DIGIT_MAX_TENS);
        w_mo_step      = bcd_step(r_min_ones, DIGIT_MAX_ONES);
        w_mt_step      = bcd_step(r_min_tens, DIGIT_MAX_TENS);
        w_pre_nxt      = r_pre;
        w_sec_ones_nxt = r_sec_ones;
        w_sec_tens_nxt = r_sec_tens;
        w_min_ones_nxt = r_min_ones;
        w_min_tens_nxt = r_min_tens;
        w_wrap_nxt     = 1'b0;
        if (w_state_nxt == IDLE) begin
            w_pre_nxt      = {PRE_W{1'b0}};
            w_sec_ones_nxt = 4'd0;
            w_sec_tens_nxt = 4'd0;
            w_min_ones_nxt = 4'd0;
            w_min_tens_nxt = 4'd0;
        end else if (w_adv) begin
            w_pre_nxt      = {PRE_W{1'b0}};
            w_sec_ones_nxt = w_so_step[3:0];
            if (w_so_step[4]) begin
                w_sec_tens_nxt = w_st_step[3:0];
                if (w_st_step[4]) begin
                    w_min_ones_nxt = w_mo_step[3:0];
                    if (w_mo_step[4]) begin
                        w_min_tens_nxt = w_mt_step[3:0];
                        w_wrap_nxt     = w_mt_step[4];
                    end else begin
                        w_min_tens_nxt = r_min_tens;
                    end
                end else begin
                    w_min_ones_nxt = r_min_ones;
                end
            end else begin
                w_sec_tens_nxt = r_sec_tens;
            end
        end else if (w_count) begin
            w_pre_nxt = r_pre + {{(PRE_W-1){1'b0}}, 1'b1};
        end else begin
            w_pre_nxt = r_pre;
        end
    end

    // State, counters and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_pre      <= {PRE_W{1'b0}};
            r_sec_ones <= 4'd0;
            r_sec_tens <= 4'd0;
            r_min_ones <= 4'd0;
            r_min_tens <= 4'd0;
            r_running  <= 1'b0;
            r_wrap     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pre      <= w_pre_nxt;
            r_sec_ones <= w_sec_ones_nxt;
            r_sec_tens <= w_sec_tens_nxt;
            r_min_ones <= w_min_ones_nxt;
            r_min_tens <= w_min_tens_nxt;
            r_running  <= (w_state_nxt == RUN);
            r_wrap     <= w_wrap_nxt;
        end
    end

    assign sec_ones = r_sec_ones;
    assign sec_tens = r_sec_tens;
    assign min_ones = r_min_ones;
    assign min_tens = r_min_tens;
    assign running  = r_running;
    assign wrap     = r_wrap;

endmodule

// File: tb/tb_stopwatch_core.sv
// Scoreboard bench for stopwatch_core: a behavioural model keeps time as a
// count of seconds and pushes the expected outputs every clock; a monitor
// pops and compares against the DUT on the falling edge.
module tb_stopwatch_core;

    localparam int TPS = 4;
    localparam int SS  = 2;
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick_in;
    logic       btn_start;
    logic       btn_clear;
    logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
    logic       running, wrap;

    typedef struct packed {
        logic [3:0] so;
        logic [3:0] st;
        logic [3:0] mo;
        logic [3:0] mt;
        logic       run;
        logic       wrp;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc_n = 0;

    stopwatch_core #(.TICKS_PER_SEC(TPS), .SYNC_STAGES(SS)) dut (
        .clk       (clk),
        .rst       (rst),
        .tick_in   (tick_in),
        .btn_start (btn_start),
        .btn_clear (btn_clear),
        .sec_ones  (sec_ones),
        .sec_tens  (sec_tens),
        .min_ones  (min_ones),
        .min_tens  (min_tens),
        .running   (running),
        .wrap      (wrap)
    );

    always #5 clk = ~clk;

    // Reference model: a button/tick event takes effect 3 + 1 edges after it is
    // first sampled high (2 sync flops, edge register, then consumption).
    initial begin : model
        logic [4:0] h_t, h_s, h_c;
        logic       tk, st, cl, wr;
        int         m_state, m_ticks, m_secs;
        exp_t       e;
        h_t = 5'd0; h_s = 5'd0; h_c = 5'd0;
        m_state = M_IDLE; m_ticks = 0; m_secs = 0;
        forever begin
            @(posedge clk);
            wr = 1'b0;
            if (rst) begin
                h_t = 5'd0; h_s = 5'd0; h_c = 5'd0;
                m_state = M_IDLE; m_ticks = 0; m_secs = 0;
            end else begin
                h_t = {h_t[3:0], tick_in};
                h_s = {h_s[3:0], btn_start};
                h_c = {h_c[3:0], btn_clear};
                tk = h_t[3] & ~h_t[4];
                st = h_s[3] & ~h_s[4];
                cl = h_c[3] & ~h_c[4];
                if (m_state == M_RUN) begin
                    if (tk) begin
                        m_ticks = m_ticks + 1;
                        if (m_ticks == TPS) begin
                            m_ticks = 0;
                            m_secs  = m_secs + 1;
                            if (m_secs == 3600) begin
                                m_secs = 0;
                                wr = 1'b1;
                            end
                        end
                    end
                    if (st) m_state = M_PAUSE;
                end else if (cl) begin
                    m_state = M_IDLE;
                end else if (st) begin
                    m_state = M_RUN;
                end
                if (m_state == M_IDLE) begin
                    m_ticks = 0;
                    m_secs  = 0;
                end
            end
            e.so  = 4'((m_secs % 60) % 10);
            e.st  = 4'((m_secs % 60) / 10);
            e.mo  = 4'((m_secs / 60) % 10);
            e.mt  = 4'((m_secs / 60) / 10);
            e.run = (m_state == M_RUN);
            e.wrp = wr;
            exp_q.push_back(e);
        end
    end

    // Monitor: compare DUT outputs with the oldest expectation each falling edge.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            cyc_n = cyc_n + 1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_cmp = n_cmp + 1;
                if ({sec_ones, sec_tens, min_ones, min_tens, running, wrap} !== e) begin
                    n_bad = n_bad + 1;
                    $display("FAIL cycle %0d outputs: got %0d%0d:%0d%0d run=%0b wrap=%0b, want %0d%0d:%0d%0d run=%0b wrap=%0b",
                             cyc_n, min_tens, min_ones, sec_tens, sec_ones, running, wrap,
                             e.mt, e.mo, e.st, e.so, e.run, e.wrp);
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tick_edges(input int n);
        for (int i = 0; i < n; i++) begin
            tick_in = 1'b1;
            cyc(1);
            tick_in = 1'b0;
            cyc(1);
        end
    endtask

    task automatic press_start();
        btn_start = 1'b1;
        cyc(4);
        btn_start = 1'b0;
        cyc(4);
    endtask

    task automatic press_clear();
        btn_clear = 1'b1;
        cyc(4);
        btn_clear = 1'b0;
        cyc(4);
    endtask

    // Stimulus: directed scenarios followed by a randomized phase.
    initial begin : stim
        rst = 1'b1; tick_in = 1'b0; btn_start = 1'b0; btn_clear = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tick_in = ~tick_in;
        end
        rst = 1'b0; tick_in = 1'b0;
        tick_edges(4);                 // idle: ticks ignored
        press_start();
        tick_edges(8);                 // 00:02
        cyc(4);
        tick_edges(14396 - 8);         // 59:59
        tick_edges(4);                 // wrap to 00:00
        cyc(4);
        press_clear();                 // ignored in RUN
        press_start();                 // PAUSE
        tick_edges(5);                 // frozen
        press_clear();                 // IDLE
        press_start();
        tick_edges(6);
        tick_in = 1'b1; btn_start = 1'b1;   // tick coincident with stop
        cyc(4);
        tick_in = 1'b0; btn_start = 1'b0;
        cyc(4);
        btn_start = 1'b1; btn_clear = 1'b1; // simultaneous in PAUSE
        cyc(4);
        btn_start = 1'b0; btn_clear = 1'b0;
        cyc(4);
        btn_start = 1'b1;                   // held: one RUN entry
        cyc(100);
        btn_start = 1'b0;
        cyc(4);
        tick_edges(37 * TPS);               // 00:37
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        cyc(4);
        btn_start = 1'b1;                   // held through reset release
        rst = 1'b1;
        cyc(3);
        rst = 1'b0;
        cyc(10);
        btn_start = 1'b0;
        tick_edges(10);
        for (int i = 0; i < 4000; i++) begin
            tick_in = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 24) == 0) btn_start = ~btn_start;
            if ($urandom_range(0, 39) == 0) btn_clear = ~btn_clear;
            if ($urandom_range(0, 149) == 0) begin
                btn_start = 1'b1;
                btn_clear = 1'b1;
            end
            rst = ($urandom_range(0, 999) == 0);
            cyc(1);
        end
        rst = 1'b0;
        cyc(3);
        n_cmp = n_cmp + 1;
        if (exp_q.size() > 2) begin
            n_bad = n_bad + 1;
            $display("FAIL queue_drain: got %0d pending, want at most 2", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
